// File: rtl/flopr.sv
// Resettable register: WIDTH-bit D flip-flop bank with synchronous, active-high reset.
// q comes straight from the flops, so there is no combinational path from d or reset to q.
`timescale 1ns/1ps

module flopr #(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset wins over d at the same edge; both are only looked at on the rising edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else begin
         q <= d;
      end
   end

endmodule

// File: tb/tb_flopr.sv
// Scoreboard bench for flopr: drives a 64-bit default instance and an 8-bit instance with reset value A5.
// Each edge's expected q is queued by the stimulus and popped by an independent monitor.
`timescale 1ns/1ps

module tb_flopr;

   localparam logic [7:0] RV8 = 8'hA5;

   typedef struct {
      logic [63:0] q64;
      logic [7:0]  q8;
   } expT;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] d;
   logic [7:0]  d8;
   logic [63:0] q;
   logic [7:0]  q8;

   expT         expQ[$];
   expT         lastExp;
   bit          haveLast = 0;
   int          checkCount = 0;
   int          passCount = 0;

   flopr dut64 (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q)
   );

   flopr #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .d     (d8),
      .q     (q8)
   );

   always #5 clk = ~clk;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: q=%h required %h at %0t", name, act, req, $time);
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
      checkCount++;
      if (act === req) passCount++;
      else $display("[TB] FAIL %s: q=%h required %h at %0t", name, act, req, $time);
   endtask

   // Reference model: the value q must hold after the coming edge is just "reset ? reset value : d".
   task automatic pushExpected();
      expT e;
      e.q64 = reset ? 64'h0 : d;
      e.q8  = reset ? RV8 : d8;
      expQ.push_back(e);
   endtask

   task automatic driveNow(input logic r, input logic [63:0] dv, input logic [7:0] dv8);
      reset = r;
      d     = dv;
      d8    = dv8;
      pushExpected();
   endtask

   task automatic applyStimulus(input logic r, input logic [63:0] dv, input logic [7:0] dv8);
      @(negedge clk);
      driveNow(r, dv, dv8);
   endtask

   // Reset pulse and d glitches that never span a rising edge; only the settled values count.
   task automatic applyGlitch(input logic [63:0] dv, input logic [7:0] dv8);
      @(negedge clk);
      reset = 1'b0;
      d     = ~dv;
      d8    = ~dv8;
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      d  = 64'hFFFF_0000_FFFF_0000;
      #1 d  = dv;
      d8 = dv8;
      pushExpected();
   endtask

   // Edge monitor: pops one expectation per rising edge that has one queued.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            lastExp = expQ.pop_front();
            check64("edge_q64", q, lastExp.q64);
            check8("edge_q8", q8, lastExp.q8);
            haveLast = 1;
         end
      end
   end

   // Mid-cycle monitor: q must not move between rising edges whatever d and reset do.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (haveLast) begin
            check64("hold_q64", q, lastExp.q64);
            check8("hold_q8", q8, lastExp.q8);
         end
      end
   end

   initial begin
      logic [63:0] rv;
      int          waitCycles;

      // Reset held for five edges with junk on d.
      driveNow(1'b1, 64'hDEADBEEF_CAFEF00D, 8'h77);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'hDEADBEEF_CAFEF00D, 8'h77);

      // First edge after release captures d; 8-bit instance shows A5 then 3C.
      applyStimulus(1'b0, 64'h0123456789ABCDEF, 8'h3C);
      applyStimulus(1'b0, 64'h0, 8'h00);

      // All-ones then reset with d still all-ones.
      applyStimulus(1'b0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      applyStimulus(1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);

      // Ten distinct values, reset over the first five edges.
      for (int i = 0; i < 10; i++) begin
         rv = {$urandom(), $urandom()};
         rv[3:0] = 4'(i);
         applyStimulus(i < 5, rv, 8'(i * 17 + 1));
      end

      // Reset pulse that falls between edges is ignored.
      applyStimulus(1'b0, 64'h1111, 8'h11);
      applyGlitch(64'h5, 8'h05);
      applyGlitch(64'h8000_0000_0000_0001, 8'h81);

      // Randomized traffic with occasional resets, including back-to-back.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 7) == 0), {$urandom(), $urandom()}, 8'($urandom()));
      end

      // Drain the scoreboard within a bounded number of edges.
      waitCycles = 0;
      while (expQ.size() != 0 && waitCycles < 20) begin
         @(posedge clk);
         #2;
         waitCycles++;
      end
      checkCount++;
      if (expQ.size() == 0) passCount++;
      else $display("[TB] FAIL drain: %0d entries left required 0", expQ.size());

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
